// File: rtl/scope_capture_engine.sv
// rtl/scope_capture_engine.sv - N-channel triggered capture into circular RAMs with oldest-first byte dump
//
// Optional feature macro: SCOPE_AUTO_TRIG_EN
//   defined   : WAIT_TRIG forces a trigger after AUTO_TMO accepted samples, flagged on trig_auto
//   undefined : WAIT_TRIG waits indefinitely, trig_auto tied low
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   smpl_vld, smpl_data    ADC sample-set strobe and data (channel k at [k*SMPL_W +: SMPL_W])
//   trig_in                asynchronous per-channel trigger comparator outputs
//   trig_src, trig_edge    trigger channel select and polarity (1 = rising)
//   trig_pos               post-trigger sample count (0 = full pre-trigger buffer)
//   decimator              keep 1 of every 2**decimator samples
//   arm, clr_cap_done      start capture / release frozen buffer back to IDLE
//   capture_done           buffer frozen and valid
//   ram_we/addr/wdata      shared write port of the per-channel RAMs
//   ram_rdata              RAM read data, valid 1 cycle after ram_addr
//   dump_req, dump_ch      request an oldest-first stream of one channel
//   dump_data/vld/rdy      sample stream with valid/ready handshake
//   dump_done, dump_err    end-of-dump pulse / rejected-request pulse
//   trig_auto              last capture was auto-triggered

module scope_capture_engine #(
    parameter int NUM_CH     = 3,
    parameter int SMPL_W     = 8,
    parameter int DEPTH_LOG2 = 9,
    parameter int DEC_W      = 4,
    parameter int AUTO_TMO   = 4096,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       smpl_vld,
    input  logic [NUM_CH*SMPL_W-1:0]   smpl_data,
    input  logic [NUM_CH-1:0]          trig_in,
    input  logic [CH_W-1:0]            trig_src,
    input  logic                       trig_edge,
    input  logic [DEPTH_LOG2-1:0]      trig_pos,
    input  logic [DEC_W-1:0]           decimator,
    input  logic                       arm,
    output logic                       capture_done,
    input  logic                       clr_cap_done,
    output logic                       ram_we,
    output logic [DEPTH_LOG2-1:0]      ram_addr,
    output logic [NUM_CH*SMPL_W-1:0]   ram_wdata,
    input  logic [NUM_CH*SMPL_W-1:0]   ram_rdata,
    input  logic                       dump_req,
    input  logic [CH_W-1:0]            dump_ch,
    output logic [SMPL_W-1:0]          dump_data,
    output logic                       dump_vld,
    input  logic                       dump_rdy,
    output logic                       dump_done,
    output logic                       dump_err,
    output logic                       trig_auto
);

    localparam int DEPTH  = 2**DEPTH_LOG2;
    localparam int CNT_W  = DEPTH_LOG2 + 1;
    localparam int DCNT_W = (2**DEC_W) - 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    typedef enum logic [2:0] {IDLE, PRE, WAIT_TRIG, POST, DONE, DUMP} state_t;

    state_t                 state;

    // Capture settings frozen at arm
    logic [CH_W-1:0]        src_l;
    logic                   edge_l;
    logic [DEPTH_LOG2-1:0]  pos_l;
    logic [DEC_W-1:0]       dec_l;

    logic [DCNT_W-1:0]      dec_cnt;
    logic [DCNT_W-1:0]      dec_max;
    logic [DEPTH_LOG2-1:0]  wr_ptr;
    logic [CNT_W-1:0]       pre_cnt;
    logic [CNT_W-1:0]       pre_next;
    logic [CNT_W-1:0]       pre_target;
    logic [DEPTH_LOG2-1:0]  post_cnt;
    logic [DEPTH_LOG2-1:0]  post_next;

    logic [NUM_CH-1:0]      trig_s1;
    logic [NUM_CH-1:0]      trig_s2;
    logic                   trig_sel;
    logic                   trig_prev;
    logic                   trig_det;
    logic                   edge_hit;
    logic                   auto_fire;
    logic                   trig_hit;

    logic [CH_W-1:0]        dch_l;
    logic [CNT_W-1:0]       rd_cnt;
    logic                   rd_ready;
    logic [SMPL_W-1:0]      rd_slice;

    logic                   accept;
    logic                   arm_ok;
    logic                   dump_ok;
    logic                   do_write;
    logic                   dump_hs;
    logic                   dump_load;

    assign dec_max    = DCNT_W'((32'd1 << dec_l) - 32'd1);
    assign accept     = smpl_vld && (dec_cnt == '0);
    assign arm_ok     = arm && (state != DUMP);
    assign pre_next   = pre_cnt + CNT_W'(1);
    assign post_next  = post_cnt + DEPTH_LOG2'(1);
    // trig_pos = 0 gives a target of DEPTH, i.e. a completely filled history
    assign pre_target = DEPTH_CNT - CNT_W'(pos_l);
    assign trig_hit   = trig_det || auto_fire;

    // A request is only honoured from a quiet DONE; arm/clear in the same cycle take precedence
    assign dump_ok = dump_req && (state == DONE) && (int'(dump_ch) < NUM_CH)
                     && !arm && !clr_cap_done;

    // The detection-cycle sample is dropped when there is no post-trigger window
    assign do_write = !arm_ok && accept &&
                      ((state == PRE) || (state == POST) ||
                       ((state == WAIT_TRIG) && !(trig_hit && (pos_l == '0))));

    assign rd_slice  = ram_rdata[dch_l*SMPL_W +: SMPL_W];
    assign dump_hs   = dump_vld && dump_rdy;
    // rd_ready marks that ram_addr has been stable a full cycle, so ram_rdata matches it
    assign dump_load = (state == DUMP) && rd_ready && (rd_cnt != DEPTH_CNT)
                       && (!dump_vld || dump_rdy);

    always_comb begin
        trig_sel = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (src_l == CH_W'(i)) begin
                trig_sel = trig_s2[i];
            end
        end
    end

    assign edge_hit = edge_l ? (trig_sel && !trig_prev) : (!trig_sel && trig_prev);

    // Two-flop synchroniser, edge flop, then registered detect pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            trig_s1   <= '0;
            trig_s2   <= '0;
            trig_prev <= 1'b0;
            trig_det  <= 1'b0;
        end else begin
            trig_s1   <= trig_in;
            trig_s2   <= trig_s1;
            trig_prev <= trig_sel;
            trig_det  <= edge_hit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            src_l        <= '0;
            edge_l       <= 1'b0;
            pos_l        <= '0;
            dec_l        <= '0;
            dec_cnt      <= '0;
            wr_ptr       <= '0;
            pre_cnt      <= '0;
            post_cnt     <= '0;
            dch_l        <= '0;
            rd_cnt       <= '0;
            rd_ready     <= 1'b0;
            capture_done <= 1'b0;
            ram_we       <= 1'b0;
            ram_addr     <= '0;
            ram_wdata    <= '0;
            dump_data    <= '0;
            dump_vld     <= 1'b0;
            dump_done    <= 1'b0;
            dump_err     <= 1'b0;
        end else begin
            ram_we    <= 1'b0;
            dump_done <= 1'b0;
            dump_err  <= dump_req && !dump_ok;

            if (smpl_vld) begin
                dec_cnt <= (dec_cnt >= dec_max) ? '0 : dec_cnt + DCNT_W'(1);
            end

            if (do_write) begin
                ram_we    <= 1'b1;
                ram_addr  <= wr_ptr;
                ram_wdata <= smpl_data;
                wr_ptr    <= wr_ptr + DEPTH_LOG2'(1);
            end

            if (arm_ok) begin
                src_l        <= trig_src;
                edge_l       <= trig_edge;
                pos_l        <= trig_pos;
                dec_l        <= decimator;
                capture_done <= 1'b0;
                wr_ptr       <= '0;
                dec_cnt      <= '0;
                pre_cnt      <= '0;
                post_cnt     <= '0;
                state        <= PRE;
            end else begin
                case (state)
                    IDLE: begin
                    end

                    PRE: begin
                        if (accept) begin
                            pre_cnt <= pre_next;
                            if (pre_next == pre_target) begin
                                state <= WAIT_TRIG;
                            end
                        end
                    end

                    WAIT_TRIG: begin
                        if (trig_hit) begin
                            post_cnt <= '0;
                            if (pos_l == '0) begin
                                capture_done <= 1'b1;
                                state        <= DONE;
                            end else if (accept) begin
                                // Sample coincident with detection is post-trigger sample #1
                                post_cnt <= DEPTH_LOG2'(1);
                                if (pos_l == DEPTH_LOG2'(1)) begin
                                    capture_done <= 1'b1;
                                    state        <= DONE;
                                end else begin
                                    state <= POST;
                                end
                            end else begin
                                state <= POST;
                            end
                        end
                    end

                    POST: begin
                        if (accept) begin
                            post_cnt <= post_next;
                            if (post_next == pos_l) begin
                                capture_done <= 1'b1;
                                state        <= DONE;
                            end
                        end
                    end

                    DONE: begin
                        if (clr_cap_done) begin
                            capture_done <= 1'b0;
                            state        <= IDLE;
                        end else if (dump_ok) begin
                            dch_l    <= dump_ch;
                            ram_addr <= wr_ptr;
                            rd_cnt   <= '0;
                            rd_ready <= 1'b0;
                            state    <= DUMP;
                        end
                    end

                    DUMP: begin
                        if (dump_load) begin
                            dump_data <= rd_slice;
                            dump_vld  <= 1'b1;
                            rd_cnt    <= rd_cnt + CNT_W'(1);
                            ram_addr  <= ram_addr + DEPTH_LOG2'(1);
                            rd_ready  <= 1'b0;
                        end else begin
                            rd_ready <= 1'b1;
                            if (dump_hs) begin
                                dump_vld <= 1'b0;
                                if (rd_cnt == DEPTH_CNT) begin
                                    dump_done <= 1'b1;
                                    state     <= DONE;
                                end
                            end
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef SCOPE_AUTO_TRIG_EN
    localparam int TMO_W = $clog2(AUTO_TMO + 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             trig_auto_q;

    assign auto_fire = (state == WAIT_TRIG) && (tmo_cnt == TMO_W'(AUTO_TMO));
    assign trig_auto = trig_auto_q;

    always_ff @(posedge clk) begin
        if (rst || arm_ok) begin
            tmo_cnt     <= '0;
            trig_auto_q <= 1'b0;
        end else begin
            if (state != WAIT_TRIG) begin
                tmo_cnt <= '0;
            end else if (accept && !auto_fire) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
            // A real detection in the same cycle wins; the capture is then not flagged
            if (auto_fire && !trig_det) begin
                trig_auto_q <= 1'b1;
            end
        end
    end
`else
    assign auto_fire = 1'b0;
    // Always low here; AUTO_TMO only matters when the auto-trigger is built in
    assign trig_auto = (AUTO_TMO < 0);
`endif

endmodule

// File: tb/tb_scope_capture_engine.sv
// tb/tb_scope_capture_engine.sv - directed self-checking bench for scope_capture_engine

module tb_scope_capture_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        smpl_vld;
    logic [23:0] smpl_data;
    logic [2:0]  trig_in;
    logic [1:0]  trig_src;
    logic        trig_edge;
    logic [8:0]  trig_pos;
    logic [3:0]  decimator;
    logic        arm;
    logic        capture_done;
    logic        clr_cap_done;
    logic        ram_we;
    logic [8:0]  ram_addr;
    logic [23:0] ram_wdata;
    logic [23:0] ram_rdata;
    logic        dump_req;
    logic [1:0]  dump_ch;
    logic [7:0]  dump_data;
    logic        dump_vld;
    logic        dump_rdy;
    logic        dump_done;
    logic        dump_err;
    logic        trig_auto;

    int n_checks = 0;
    int n_pass   = 0;
    int ramp     = 0;

    logic [8:0]  waddr[$];
    logic [7:0]  wdata[$];
    logic [23:0] mem [512];

    scope_capture_engine dut (
        .clk          (clk),
        .rst          (rst),
        .smpl_vld     (smpl_vld),
        .smpl_data    (smpl_data),
        .trig_in      (trig_in),
        .trig_src     (trig_src),
        .trig_edge    (trig_edge),
        .trig_pos     (trig_pos),
        .decimator    (decimator),
        .arm          (arm),
        .capture_done (capture_done),
        .clr_cap_done (clr_cap_done),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata),
        .dump_req     (dump_req),
        .dump_ch      (dump_ch),
        .dump_data    (dump_data),
        .dump_vld     (dump_vld),
        .dump_rdy     (dump_rdy),
        .dump_done    (dump_done),
        .dump_err     (dump_err),
        .trig_auto    (trig_auto)
    );

    always #5 clk = ~clk;

    // Synchronous RAM with one-cycle read latency
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    always @(negedge clk) begin
        if (ram_we) begin
            waddr.push_back(ram_addr);
            wdata.push_back(ram_wdata[7:0]);
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic logic [23:0] mk(input int v);
        logic [7:0] a;
        a = 8'(v);
        return {a + 8'd128, a + 8'd64, a};
    endfunction

    task automatic do_arm(input int pos, input int dec);
        trig_src  = 2'd1;
        trig_edge = 1'b1;
        trig_pos  = 9'(pos);
        decimator = 4'(dec);
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        waddr.delete();
        wdata.delete();
        ramp = 0;
    endtask

    task automatic send(input int n);
        for (int i = 0; i < n; i++) begin
            smpl_data = mk(ramp);
            smpl_vld  = 1'b1;
            @(negedge clk);
            smpl_vld = 1'b0;
            ramp++;
            @(negedge clk);
        end
    endtask

    task automatic reject(input string tag, input int ch);
        dump_ch  = 2'(ch);
        dump_req = 1'b1;
        @(negedge clk);
        dump_req = 1'b0;
        check({tag, "_err_pulse"}, dump_err, 1);
        @(negedge clk);
        check({tag, "_err_clear"}, dump_err, 0);
        check({tag, "_no_vld"}, dump_vld, 0);
    endtask

    task automatic do_dump(input int ch, input bit rnd, input int first);
        int n = 0;
        int ndone = 0;
        int lat = -1;
        int t_end = 0;
        bit stall = 1'b0;
        logic [7:0] held = '0;
        dump_ch  = 2'(ch);
        dump_rdy = 1'b1;
        dump_req = 1'b1;
        @(negedge clk);
        dump_req = 1'b0;
        for (int cyc = 1; cyc <= 5000; cyc++) begin
            if (stall) check("dump_hold", {dump_vld, dump_data}, {1'b1, held});
            if (dump_done) begin
                ndone++;
                t_end = cyc;
                break;
            end
            if (dump_vld && lat < 0) lat = cyc;
            dump_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (dump_vld && dump_rdy) begin
                check("dump_data", dump_data, (first + n + ch * 64) & 255);
                n++;
            end
            stall = dump_vld && !dump_rdy;
            held  = dump_data;
            @(negedge clk);
        end
        check("dump_done_seen", ndone, 1);
        dump_rdy = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (dump_done) ndone++;
        end
        check("dump_done_once", ndone, 1);
        check("dump_count", n, 512);
        check("dump_vld_after", dump_vld, 0);
        check("dump_latency_le3", int'(lat >= 1 && lat <= 3), 1);
        if (!rnd) check("dump_rate", int'(t_end - lat <= 1026), 1);
        check("done_kept_after_dump", capture_done, 1);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int nd;
        rst = 1'b1; smpl_vld = 1'b0; smpl_data = '0; trig_in = '0;
        trig_src = '0; trig_edge = 1'b1; trig_pos = '0; decimator = '0;
        arm = 1'b0; clr_cap_done = 1'b0; dump_req = 1'b0; dump_ch = '0; dump_rdy = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_capture_done", capture_done, 0);
        check("rst_dump_vld", dump_vld, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_dump_done", dump_done, 0);
        check("rst_dump_err", dump_err, 0);
        check("rst_trig_auto", trig_auto, 0);

        // Main capture: 412 pre samples needed, early edge in PRE must be ignored
        do_arm(100, 0);
        trig_pos = 9'd7; decimator = 4'd5; trig_src = 2'd0;
        send(100);
        trig_in[1] = 1'b1;
        send(10);
        trig_in[1] = 1'b0;
        send(340);
        check("no_early_trigger", capture_done, 0);
        trig_in[1] = 1'b1;
        repeat (8) @(negedge clk);
        send(99);
        check("post_not_done_99", capture_done, 0);
        send(1);
        check("post_done_100", capture_done, 1);
        trig_in[1] = 1'b0;
        check("write_count", waddr.size(), 550);
        check("last_write_addr", waddr[549], 37);
        check("last_write_data", wdata[549], 37);
        check("dec_write_data_0", wdata[412], 412 & 255);

        reject("bad_ch", 3);
        check("bad_ch_done_kept", capture_done, 1);
        do_dump(0, 1'b0, 38);
        do_dump(2, 1'b1, 38);

        // Reset in the middle of a dump
        dump_ch = 2'd1; dump_req = 1'b1;
        @(negedge clk);
        dump_req = 1'b0;
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_dump_vld_drop", dump_vld, 0);
        check("rst_dump_capture_done", capture_done, 0);
        nd = 0;
        repeat (10) begin
            if (dump_done) nd++;
            @(negedge clk);
        end
        check("rst_no_dump_done", nd, 0);

        // Decimation by 8
        do_arm(0, 3);
        send(64);
        check("dec_write_count", waddr.size(), 8);
        for (int i = 0; i < 8; i++) begin
            check("dec_data", wdata[i], i * 8);
            check("dec_addr", waddr[i], i);
        end

        // Rejections while capturing, then re-arm in POST
        do_arm(200, 0);
        send(20);
        reject("req_in_pre", 0);
        send(300);
        reject("req_in_wait", 0);
        trig_in[1] = 1'b1;
        repeat (8) @(negedge clk);
        send(50);
        check("mid_post_not_done", capture_done, 0);
        do_arm(200, 0);
        send(3);
        check("rearm_writes", waddr.size(), 3);
        check("rearm_addr0", waddr[0], 0);
        check("rearm_data0", wdata[0], 0);
        check("rearm_addr2", waddr[2], 2);
        send(600);
        check("no_trigger_waits", capture_done, 0);
        check("no_auto_trigger", trig_auto, 0);

        // trig_pos = 0: detection freezes without writing the detection sample
        trig_in[1] = 1'b0;
        repeat (6) @(negedge clk);
        do_arm(0, 0);
        send(520);
        trig_in[1] = 1'b1;
        repeat (8) @(negedge clk);
        check("pos0_done", capture_done, 1);
        check("pos0_writes", waddr.size(), 520);
        send(2);
        check("pos0_no_more_writes", waddr.size(), 520);
        do_dump(0, 1'b0, 8);
        check("pos0_trig_auto", trig_auto, 0);

        clr_cap_done = 1'b1;
        @(negedge clk);
        clr_cap_done = 1'b0;
        check("clr_cap_done", capture_done, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
